// File: rtl/alu_checker.sv
// rtl/alu_checker.sv - in-line ALU result checker with pass/fail statistics and first-fail capture
// Optional: ALU_CHECKER_HALT_ON_FAIL_EN stops accepting transactions once a mismatch is recorded.
module alu_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [31:0]      op_0,
    input  logic [31:0]      op_1,
    input  logic [31:0]      dut_out,
    input  logic             dut_zero,
    input  logic             dut_negative,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             error_sticky,
    output logic [2:0]       first_fail_opcode,
    output logic [31:0]      first_fail_expected,
    output logic [31:0]      first_fail_actual
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic        s1_valid;
    logic [2:0]  s1_opcode;
    logic [31:0] s1_expected;
    logic [31:0] s1_actual;
    logic        s1_zero;
    logic        s1_neg;

    logic [31:0] exp_result;
    logic [4:0]  shamt;
    logic        accept;
    logic        mismatch;
    logic        unused_shift_bits;

    // Shift amount uses only the low five bits; the upper operand bits are don't-care.
    assign shamt             = op_1[4:0];
    assign unused_shift_bits = ^op_1[31:5];

    always_comb begin
        exp_result = 32'd0;
        case (opcode)
            OP_ADD:  exp_result = op_0 + op_1;
            OP_SUB:  exp_result = op_0 - op_1;
            OP_AND:  exp_result = op_0 & op_1;
            OP_OR:   exp_result = op_0 | op_1;
            OP_XOR:  exp_result = op_0 ^ op_1;
            OP_SLL:  exp_result = op_0 << shamt;
            OP_SRL:  exp_result = op_0 >> shamt;
            OP_SRA:  exp_result = $unsigned($signed(op_0) >>> shamt);
            default: exp_result = 32'd0;
        endcase
    end

`ifdef ALU_CHECKER_HALT_ON_FAIL_EN
    assign in_ready = ~error_sticky;
`else
    assign in_ready = 1'b1;
`endif

    assign accept   = in_valid && in_ready && !clear;
    assign mismatch = (s1_actual != s1_expected)
                   || (s1_zero != (s1_expected == 32'd0))
                   || (s1_neg != s1_expected[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid            <= 1'b0;
            s1_opcode           <= 3'd0;
            s1_expected         <= 32'd0;
            s1_actual           <= 32'd0;
            s1_zero             <= 1'b0;
            s1_neg              <= 1'b0;
            pass_count          <= '0;
            fail_count          <= '0;
            error_sticky        <= 1'b0;
            first_fail_opcode   <= 3'd0;
            first_fail_expected <= 32'd0;
            first_fail_actual   <= 32'd0;
        end else if (clear) begin
            s1_valid            <= 1'b0;
            pass_count          <= '0;
            fail_count          <= '0;
            error_sticky        <= 1'b0;
            first_fail_opcode   <= 3'd0;
            first_fail_expected <= 32'd0;
            first_fail_actual   <= 32'd0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_opcode   <= opcode;
                s1_expected <= exp_result;
                s1_actual   <= dut_out;
                s1_zero     <= dut_zero;
                s1_neg      <= dut_negative;
            end
            if (s1_valid) begin
                if (mismatch) begin
                    if (fail_count != CNT_MAX) begin
                        fail_count <= fail_count + CNT_ONE;
                    end
                    if (!error_sticky) begin
                        error_sticky        <= 1'b1;
                        first_fail_opcode   <= s1_opcode;
                        first_fail_expected <= s1_expected;
                        first_fail_actual   <= s1_actual;
                    end
                end else if (pass_count != CNT_MAX) begin
                    pass_count <= pass_count + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_checker.sv
// tb/tb_alu_checker.sv - table-driven scoreboard bench for alu_checker (CNT_W=4)
module tb_alu_checker;
    localparam int CNT_W = 4;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7;
`ifdef ALU_CHECKER_HALT_ON_FAIL_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [31:0]      op_0, op_1, dut_out;
    logic             dut_zero, dut_negative, clear;
    logic [CNT_W-1:0] pass_count, fail_count;
    logic             error_sticky;
    logic [2:0]       first_fail_opcode;
    logic [31:0]      first_fail_expected, first_fail_actual;

    alu_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_0(op_0), .op_1(op_1), .dut_out(dut_out),
        .dut_zero(dut_zero), .dut_negative(dut_negative), .clear(clear),
        .pass_count(pass_count), .fail_count(fail_count), .error_sticky(error_sticky),
        .first_fail_opcode(first_fail_opcode), .first_fail_expected(first_fail_expected),
        .first_fail_actual(first_fail_actual)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dout;
        logic        dz;
        logic        dn;
        logic        bad;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        logic        bad;
        logic [2:0]  op;
        logic [31:0] expv;
        logic [31:0] act;
    } sb_t;

    vec_t vecs[13];
    sb_t  sbq[$];

    int total = 0;
    int bad = 0;

    logic [CNT_W-1:0] m_pass, m_fail;
    logic             m_sticky;
    logic [2:0]       m_ff_op;
    logic [31:0]      m_ff_exp, m_ff_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_pass = '0; m_fail = '0; m_sticky = 1'b0;
        m_ff_op = 3'd0; m_ff_exp = 32'd0; m_ff_act = 32'd0;
        sbq.delete();
    endtask

    task automatic step(input logic v, input vec_t t, input logic clr);
        logic acc;
        logic m_ready;
        sb_t  e;
        m_ready = HALT ? !m_sticky : 1'b1;
        in_valid = v; opcode = t.op; op_0 = t.a; op_1 = t.b; dut_out = t.dout;
        dut_zero = t.dz; dut_negative = t.dn; clear = clr;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        acc = v && m_ready && !clr;
        @(posedge clk);
        if (clr) begin
            model_clear();
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.bad) begin
                    if (m_fail != '1) m_fail = m_fail + 1'b1;
                    if (!m_sticky) begin
                        m_sticky = 1'b1; m_ff_op = e.op; m_ff_exp = e.expv; m_ff_act = e.act;
                    end
                end else if (m_pass != '1) begin
                    m_pass = m_pass + 1'b1;
                end
            end
            if (acc) sbq.push_back('{t.bad, t.op, t.expv, t.dout});
        end
        #1;
        chk("pass_count", {28'd0, pass_count}, {28'd0, m_pass});
        chk("fail_count", {28'd0, fail_count}, {28'd0, m_fail});
        chk("error_sticky", {31'd0, error_sticky}, {31'd0, m_sticky});
    endtask

    task automatic idle(input int n);
        vec_t z;
        z = '{3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
        for (int i = 0; i < n; i++) step(1'b0, z, 1'b0);
    endtask

    task automatic chk_capture(input string tag);
        chk({tag, "_ff_opcode"}, {29'd0, first_fail_opcode}, {29'd0, m_ff_op});
        chk({tag, "_ff_expected"}, first_fail_expected, m_ff_exp);
        chk({tag, "_ff_actual"}, first_fail_actual, m_ff_act);
    endtask

    initial begin
        vec_t pv, fv;
        vecs[0]  = '{OP_ADD, 32'd15, 32'd10, 32'd25, 1'b0, 1'b0, 1'b0, 32'd25};
        vecs[1]  = '{OP_SUB, 32'd5, 32'd20, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF1};
        vecs[2]  = '{OP_SRA, 32'hFFFF_FF88, 32'd3, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF1};
        vecs[3]  = '{OP_SLL, 32'd15, 32'h24, 32'd240, 1'b0, 1'b0, 1'b0, 32'd240};
        vecs[4]  = '{OP_XOR, 32'hAA, 32'hCC, 32'h67, 1'b0, 1'b0, 1'b1, 32'h66};
        vecs[5]  = '{OP_AND, 32'hAA, 32'hCC, 32'h88, 1'b1, 1'b0, 1'b1, 32'h88};
        vecs[6]  = '{OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0, 32'hFF};
        vecs[7]  = '{OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[8]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[9]  = '{OP_SUB, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{OP_SRA, 32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[11] = '{OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h8000_0000};
        vecs[12] = '{OP_AND, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000};
        pv = vecs[0];
        fv = vecs[4];

        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; opcode = 3'd0;
        op_0 = 32'd0; op_1 = 32'd0; dut_out = 32'd0; dut_zero = 1'b0; dut_negative = 1'b0;
        model_clear();
        #12;
        chk("reset_pass", {28'd0, pass_count}, 32'd0);
        chk("reset_fail", {28'd0, fail_count}, 32'd0);
        chk("reset_sticky", {31'd0, error_sticky}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        chk_capture("reset");
        rst_n = 1'b1;

        // Back-to-back table run; counters are checked after every edge.
        for (int i = 0; i < 13; i++) step(1'b1, vecs[i], 1'b0);
        idle(2);
        chk_capture("table");
        if (!HALT) begin
            chk("xor_ff_opcode", {29'd0, first_fail_opcode}, {29'd0, OP_XOR});
            chk("xor_ff_expected", first_fail_expected, 32'h66);
            chk("xor_ff_actual", first_fail_actual, 32'h67);
        end

        // Clear with one transaction in flight and another presented alongside.
        step(1'b1, pv, 1'b0);
        step(1'b1, pv, 1'b1);
        idle(2);
        chk_capture("clear");
        chk("clear_ready", {31'd0, in_ready}, 32'd1);

        // Saturation: 17 matches pin pass_count at 15, then a failure still counts.
        for (int i = 0; i < 17; i++) step(1'b1, pv, 1'b0);
        step(1'b1, fv, 1'b0);
        idle(2);
        chk("sat_pass", {28'd0, pass_count}, 32'd15);
        chk("sat_fail", {28'd0, fail_count}, 32'd1);
        chk_capture("sat");

        // Asynchronous reset with a transaction in stage 1.
        step(1'b1, pv, 1'b1);
        step(1'b1, pv, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("areset_pass", {28'd0, pass_count}, 32'd0);
        chk("areset_sticky", {31'd0, error_sticky}, 32'd0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_checker.md
Name: alu_checker

Overview:
- Response-side companion to the ALU. It samples each ALU transaction (opcode, operands, result, flags) through a valid/ready handshake and recomputes the expected result and flags with an internal reference model.
- It compares the two and keeps pass/fail counters plus a capture of the first failing transaction.
- It sits beside the ALU in unit benches and in the core's debug path, so ALU results are checked in-line instead of by reading printed output.

Parameters:
- CNT_W, 16, width of the pass and fail counters; both saturate at all-ones.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  transaction present on the inputs
- in_ready  output  1  checker accepts a transaction this cycle
- opcode  input  3  ALU opcode, encoded per the ALU_OPERATION_* macros (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA)
- op_0  input  32  ALU operand 0
- op_1  input  32  ALU operand 1
- dut_out  input  32  ALU result under check
- dut_zero  input  1  ALU ZERO flag under check
- dut_negative  input  1  ALU NEGATIVE flag under check
- clear  input  1  synchronous clear of all statistics and the pipeline
- pass_count  output  CNT_W  number of matching transactions
- fail_count  output  CNT_W  number of mismatching transactions
- error_sticky  output  1  set on the first mismatch; held until clear or reset
- first_fail_opcode  output  3  opcode of the first failing transaction
- first_fail_expected  output  32  expected result of the first failure
- first_fail_actual  output  32  dut_out of the first failure

Behaviour:
- Reset (rst_n low, asynchronous): every output register goes to 0, both pipeline stages go invalid, in_ready = 1.
- Accept: a transaction is taken at a rising edge when in_valid && in_ready. Back-to-back acceptance is supported, one per cycle.
- Stage 1 (edge N): registers opcode, op_0, op_1, dut_out and both flags, and computes the expected result:
  - ADD: op_0+op_1; SUB: op_0-op_1. Both are modulo 2^32 and ignore carry/overflow.
  - AND, OR, XOR: bitwise.
  - SLL, SRL, SRA: shift op_0 by op_1[4:0]; op_1[31:5] is ignored. SRA replicates op_0[31].
  - exp_zero = (exp==0); exp_neg = exp[31].
- Stage 2 (edge N+1): mismatch = (dut_out != exp) || (dut_zero != exp_zero) || (dut_negative != exp_neg).
  - Match: pass_count++.
  - Mismatch: fail_count++. If error_sticky is 0, it sets and first_fail_* load.
  - Counters are visible two edges after acceptance.
- Saturation: a counter at all-ones holds. Only the counter that would overflow stops; checking continues.
- First-fail capture loads only while error_sticky = 0. Later failures never overwrite it.
- clear (synchronous, priority over everything except reset):
  - zeroes the counters, error_sticky and first_fail_*;
  - invalidates both pipeline stages, so in-flight transactions are dropped uncounted;
  - drops any transaction presented in the same cycle, even if in_valid && in_ready.
- Asynchronous reset mid-stream: in-flight transactions are discarded; nothing is counted after reset releases until a new accept.
- in_ready depends only on registered state, never combinationally on in_valid.

Optional Feature:
- Macro: ALU_CHECKER_HALT_ON_FAIL_EN.
- Defined:
  - in_ready deasserts the cycle after error_sticky sets and stays low until clear or reset.
  - A transaction already in stage 1 when the failure registers still completes and is counted.
- Not defined: in_ready is constant 1.

Test Plan:
- ADD 15+10 with dut_out=25, zero=0, neg=0 -> pass_count=1 two edges after accept; fail_count=0; error_sticky=0.
- SUB 5-20 with dut_out=32'hFFFFFFF1, neg=1, then SRA 32'hFFFFFF88 by 3 with dut_out=32'hFFFFFFF1, neg=1 -> pass_count=2.
- SLL 15 by op_1=32'h24 (only [4:0]=4 used) with dut_out=240, then XOR 0xAA^0xCC with dut_out=0x67 (correct value 0x66) -> pass_count=1, fail_count=1, error_sticky=1, first_fail_opcode=XOR, first_fail_expected=0x66, first_fail_actual=0x67.
- Second failure: AND 0xAA&0xCC with dut_out=0x88 (correct) but dut_zero=1 -> fail_count=2; first_fail_* still hold the XOR values.
- clear asserted together with an in_valid ADD and a stage-2 transaction in flight -> all counters 0, error_sticky=0, no count change on the next two edges. Separately, preload pass_count to all-ones via 2^CNT_W matching transactions with CNT_W=4 -> holds 15.
- With ALU_CHECKER_HALT_ON_FAIL_EN: a failing transaction -> in_ready=0 from the cycle after error_sticky sets and no further accepts; clear -> in_ready=1 next cycle.
